// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among N_REQ byte producers.
// Optional per-message lock is enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int IDW     = 2,
   parameter int BUSY_TO = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_vld,
   input  logic [N_REQ*8-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_rdy,
   output logic [7:0]         tx_din,
   output logic               tx_vld,
   input  logic               busy,
   output logic [IDW-1:0]     grant_id,
   output logic               lock_active,
   output logic               busy_timeout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [7:0]       hold;
   logic [7:0]       cnt;
   logic [N_REQ-1:0] cand;
   logic             win_found;
   logic [IDW-1:0]   win;
   logic             accept;
   logic             timeout_hit;

`ifdef UART_TX_ARB_LOCK_EN
   logic           locked;
   logic [IDW-1:0] owner;

   // While a message is open only its owner is eligible.
   always_comb begin
      cand = req_vld;
      if (locked)
         cand = req_vld & ({{(N_REQ-1){1'b0}}, 1'b1} << owner);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         locked <= 1'b0;
         owner  <= '0;
      end else if (accept) begin
         locked <= ~req_last[win];
         owner  <= win;
      end
   end

   assign lock_active = locked;
`else
   logic unused_last;

   assign cand        = req_vld;
   assign lock_active = 1'b0;
   assign unused_last = ^req_last;
`endif

   // First candidate at or above rr_ptr, wrapping at N_REQ-1.
   always_comb begin
      int             idx;
      logic [IDW-1:0] sel;
      idx       = 0;
      sel       = '0;
      win_found = 1'b0;
      win       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         sel = idx[IDW-1:0];
         if (!win_found && cand[sel]) begin
            win_found = 1'b1;
            win       = sel;
         end
      end
   end

   assign accept      = (state == IDLE) && !busy && win_found && !rst;
   assign req_rdy     = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
   assign tx_vld      = (state == ISSUE);
   assign tx_din      = hold;
   assign timeout_hit = (state == WAIT_BUSY) && !busy && (cnt == 8'(BUSY_TO-1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (busy)             state_nxt = WAIT_DONE;
            else if (timeout_hit) state_nxt = IDLE;
         end
         WAIT_DONE: if (!busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         hold         <= 8'h00;
         grant_id     <= '0;
         cnt          <= 8'h00;
         busy_timeout <= 1'b0;
      end else begin
         busy_timeout <= timeout_hit;
         if (accept) begin
            hold     <= req_data[{win, 3'b000} +: 8];
            grant_id <= win;
            rr_ptr   <= (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
         end
         if (state == ISSUE)
            cnt <= 8'h00;
         else if (state == WAIT_BUSY && !busy)
            cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus queues expected issues,
// a monitor pops and compares on every tx_vld.
module tb_uart_tx_arbiter;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int BTO = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_vld  = '0;
   logic [N*8-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_rdy;
   logic [7:0]     tx_din;
   logic           tx_vld;
   logic           busy = 1'b0;
   logic [IDW-1:0] grant_id;
   logic           lock_active;
   logic           busy_timeout;

   uart_tx_arbiter #(.N_REQ(N), .IDW(IDW), .BUSY_TO(BTO)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
      .req_last(req_last), .req_rdy(req_rdy), .tx_din(tx_din), .tx_vld(tx_vld),
      .busy(busy), .grant_id(grant_id), .lock_active(lock_active),
      .busy_timeout(busy_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [7:0]     d;
      logic           lk;
   } exp_t;

   exp_t       expq[$];
   logic [8:0] rq[N][$];   // {last, byte} per requester
   int         errors = 0;
   int         checks = 0;
   bit         model_en = 1'b1;
   bit         busy_force = 1'b0;
   int         busy_len = 3;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_req(input int r, input logic last, input logic [7:0] d);
      rq[r].push_back({last, d});
   endtask

   task automatic push_exp(input int id, input logic [7:0] d, input logic lk);
      exp_t e;
      e.id = IDW'(id); e.d = d; e.lk = lk;
      expq.push_back(e);
   endtask

   // Requester drivers and uart_tx busy model; all inputs except rst change at posedge+1.
   initial begin : drv
      logic [N-1:0] acc;
      logic         v;
      int           bcnt;
      bcnt = 0;
      forever begin
         @(negedge clk);
         acc = req_rdy;
         v   = tx_vld;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++)
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
               req_vld[i]        = 1'b1;
               req_data[i*8 +: 8] = rq[i][0][7:0];
               req_last[i]       = rq[i][0][8];
            end else begin
               req_vld[i]        = 1'b0;
               req_data[i*8 +: 8] = 8'h00;
               req_last[i]       = 1'b0;
            end
         end
         if (model_en) begin
            if (bcnt > 0) begin
               bcnt--;
               if (bcnt == 0) busy = 1'b0;
            end
            if (v) begin
               busy = 1'b1;
               bcnt = busy_len;
            end
         end else begin
            busy = busy_force;
            bcnt = 0;
         end
      end
   end

   // Monitor: one-hot grant, accept spacing, issue latency and scoreboard compare.
   initial begin : mon
      int   last_acc;
      bit   have_acc;
      exp_t e;
      last_acc = 0;
      have_acc = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (req_rdy != '0) begin
               chk($countones(req_rdy) == 1, "rdy_onehot", int'(req_rdy), 1);
               if (have_acc) chk(cyc - last_acc >= 4, "accept_spacing", cyc - last_acc, 4);
               last_acc = cyc;
               have_acc = 1'b1;
            end
            if (tx_vld) begin
               chk(have_acc && last_acc == cyc - 1, "issue_latency", cyc - last_acc, 1);
               if (expq.size() == 0) begin
                  chk(1'b0, "unexpected_tx", int'(tx_din), -1);
               end else begin
                  e = expq.pop_front();
                  chk(tx_din == e.d, "tx_din", int'(tx_din), int'(e.d));
                  chk(grant_id == e.id, "grant_id", int'(grant_id), int'(e.id));
                  chk(lock_active == e.lk, "lock_active", int'(lock_active), int'(e.lk));
               end
            end
         end
      end
   end

   task automatic apply_reset(input int n);
      @(posedge clk); #1 rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_acc(output int c);
      c = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (req_rdy != '0) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) chk(1'b0, "accept_wait_expired", 0, 1);
   endtask

   task automatic drain();
      int run;
      run = 0;
      for (int k = 0; k < 600 && run < 6; k++) begin
         @(negedge clk);
         if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
             rq[3].size() == 0 && expq.size() == 0 && !busy && !tx_vld) run++;
         else run = 0;
      end
      chk(expq.size() == 0, "drain_pending", expq.size(), 0);
   endtask

   initial begin : wdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int a1, a2, tc, tc2, npulse;
      bit seen, acc_at_to;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(req_rdy == '0, "rst_req_rdy", int'(req_rdy), 0);
      chk(tx_vld == 1'b0, "rst_tx_vld", int'(tx_vld), 0);
      chk(tx_din == 8'h00, "rst_tx_din", int'(tx_din), 0);
      chk(grant_id == '0, "rst_grant_id", int'(grant_id), 0);
      chk(lock_active == 1'b0, "rst_lock_active", int'(lock_active), 0);
      chk(busy_timeout == 1'b0, "rst_busy_timeout", int'(busy_timeout), 0);
      npulse = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_vld) npulse++;
      end
      chk(npulse == 0, "idle_tx_pulses", npulse, 0);

      // Single byte from requester 2, busy for 20 cycles
      apply_reset(3);
      busy_len = 20;
      push_req(2, 1'b1, 8'hA5); push_exp(2, 8'hA5, 1'b0);
      push_req(2, 1'b1, 8'h5A); push_exp(2, 8'h5A, 1'b0);
      wait_acc(a1);
      chk(req_rdy == 4'b0100, "single_rdy", int'(req_rdy), 4);
      @(negedge clk);
      chk(tx_vld == 1'b1, "single_tx_vld", int'(tx_vld), 1);
      chk(tx_din == 8'hA5, "single_tx_din", int'(tx_din), 'hA5);
      chk(grant_id == 2'd2, "single_grant", int'(grant_id), 2);
      wait_acc(a2);
      chk(a2 - a1 == 23, "single_next_accept", a2 - a1, 23);
      drain();

      // Round-robin over four always-valid requesters
      apply_reset(2);
      busy_len = 3;
      for (int r = 0; r < N; r++) begin
         push_req(r, 1'b1, 8'h10 + 8'(r));
         push_req(r, 1'b1, 8'h10 + 8'(r));
      end
      for (int k = 0; k < 8; k++) push_exp(k % N, 8'h10 + 8'(k % N), 1'b0);
      drain();

      // Lock: req1 sends a 3-byte message while req0 stays valid
      apply_reset(2);
      busy_len = 2;
      push_req(0, 1'b1, 8'h01); push_exp(0, 8'h01, 1'b0);
      drain();
      push_req(1, 1'b0, 8'hB1); push_req(1, 1'b0, 8'hB2); push_req(1, 1'b1, 8'hB3);
      push_req(0, 1'b1, 8'hC0); push_req(0, 1'b1, 8'hC1);
`ifdef UART_TX_ARB_LOCK_EN
      push_exp(1, 8'hB1, 1'b1);
      push_exp(1, 8'hB2, 1'b1);
      push_exp(1, 8'hB3, 1'b0);
      push_exp(0, 8'hC0, 1'b0);
      push_exp(0, 8'hC1, 1'b0);
`else
      push_exp(1, 8'hB1, 1'b0);
      push_exp(0, 8'hC0, 1'b0);
      push_exp(1, 8'hB2, 1'b0);
      push_exp(0, 8'hC1, 1'b0);
      push_exp(1, 8'hB3, 1'b0);
`endif
      drain();

      // Busy never rises: timeout then re-accept
      apply_reset(2);
      model_en = 1'b0; busy_force = 1'b0;
      push_req(3, 1'b1, 8'hDD); push_exp(3, 8'hDD, 1'b0);
      push_req(3, 1'b1, 8'hEE); push_exp(3, 8'hEE, 1'b0);
      wait_acc(a1);
      tc = -1; acc_at_to = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (busy_timeout) begin
            tc = cyc;
            acc_at_to = (req_rdy == 4'b1000);
            break;
         end
      end
      chk(tc - a1 == BTO + 2, "timeout_cycle", tc - a1, BTO + 2);
      chk(acc_at_to, "timeout_reaccept", int'(req_rdy), 8);
      @(negedge clk);
      chk(busy_timeout == 1'b0, "timeout_pulse_width", int'(busy_timeout), 0);
      tc2 = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (busy_timeout) begin
            tc2 = cyc;
            break;
         end
      end
      chk(tc2 - tc == BTO + 2, "timeout_second", tc2 - tc, BTO + 2);
      drain();

      // Reset while waiting for busy to fall
      apply_reset(2);
      push_req(2, 1'b1, 8'h77); push_exp(2, 8'h77, 1'b0);
      wait_acc(a1);
      busy_force = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      push_req(1, 1'b1, 8'h99); push_exp(1, 8'h99, 1'b0);
      @(negedge clk);
      chk(tx_vld == 1'b0, "midrst_tx_vld", int'(tx_vld), 0);
      chk(tx_din == 8'h00, "midrst_tx_din", int'(tx_din), 0);
      chk(grant_id == '0, "midrst_grant_id", int'(grant_id), 0);
      chk(req_rdy == '0, "midrst_req_rdy", int'(req_rdy), 0);
      chk(busy_timeout == 1'b0, "midrst_busy_timeout", int'(busy_timeout), 0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (tx_vld || req_rdy != '0) seen = 1'b1;
      end
      chk(!seen, "midrst_quiet_while_busy", int'(seen), 0);
      busy_force = 1'b0;
      wait_acc(a2);
      chk(req_rdy == 4'b0010, "midrst_new_accept", int'(req_rdy), 2);
      drain();
      model_en = 1'b1;

      chk(expq.size() == 0, "scoreboard_empty", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single `uart_tx` transmitter among `N_REQ` byte producers, such as the echo control path, a status reporter and a debug dumper. It accepts one byte at a time from the winning requester over a valid/ready handshake. It issues the byte to the transmitter as a one-cycle `tx_vld` pulse and tracks the transmitter's `busy` line until the byte has been sent. It sits between the requesters and `uart_tx`, replacing the direct `control` → `uart_tx` connection.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `grant_id`; must equal `$clog2(N_REQ)`.
- `BUSY_TO`, default 16: maximum number of cycles to wait for `busy` to rise after issue, 2..255.

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: synchronous, active-high reset.
- `req_vld` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*8: byte for requester i at bits [8i+7:8i].
- `req_last` in N_REQ: marks the final byte of a message; used only with lock.
- `req_rdy` out N_REQ: one-hot accept strobe.
- `tx_din` out 8: byte to `uart_tx`.
- `tx_vld` out 1: one-cycle issue pulse to `uart_tx`.
- `busy` in 1: `uart_tx` busy.
- `grant_id` out IDW: index of the last accepted requester.
- `lock_active` out 1: a message lock is held; always 0 when the lock is compiled out.
- `busy_timeout` out 1: one-cycle pulse when the busy wait times out.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitration runs only when `busy`=0.
  - The candidate set is all requesters with `req_vld`=1, restricted to the owner when a lock is held.
  - The winner is the first set bit searching from `rr_ptr` upward, wrapping at N_REQ-1 → 0.
  - On a winner w: `req_rdy[w]`=1 combinationally in the same cycle, `req_data[w]` is latched into `hold`, `grant_id`←w, `rr_ptr`←(w+1) mod N_REQ, and the FSM goes to ISSUE.
  - With no winner, the FSM stays in IDLE and `req_rdy`=0.
- ISSUE: `tx_vld`=1, `tx_din`=`hold`, the timeout counter is cleared, and the FSM goes to WAIT_BUSY.
- WAIT_BUSY:
  - If `busy`=1, go to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TO-1 with `busy` still 0, pulse `busy_timeout` and go to IDLE.
- WAIT_DONE: when `busy`=0, go to IDLE.
- A requester may drop `req_vld` at any time. The byte is committed only in the cycle where `req_rdy` is high.
- `rr_ptr` updates only on accept, so an idle requester never loses its turn.
- Simultaneous requests: exactly one `req_rdy` bit is ever set.
- Reset mid-operation returns the FSM to IDLE with no further `tx_vld` issued. Any byte in flight inside `uart_tx` is not aborted.
- Reset values: `req_rdy`=0, `tx_vld`=0, `tx_din`=8'h00, `grant_id`=0, `lock_active`=0, `busy_timeout`=0, `rr_ptr`=0, FSM=IDLE.

## Timing
- Accept at cycle t (IDLE, `req_rdy` high). `tx_vld` is high at t+1 (ISSUE). WAIT_BUSY is entered at t+2.
- `tx_din` is registered and stable from t+1 until the next accept.
- If `busy` is sampled high at t+2, the FSM is in WAIT_DONE at t+3.
- The earliest next accept is the first IDLE cycle after `busy` falls. `busy` falling at cycle u gives IDLE at u+1 and accept at u+1 at the earliest.
- Minimum spacing between accepts: 4 cycles (timeout case: BUSY_TO+2).
- `tx_vld` is never asserted twice without an intervening IDLE.
- `busy` is only sampled. No combinational path exists from `busy` to `tx_vld`.
- `req_rdy` depends combinationally on `req_vld`, `busy`, `rr_ptr`, lock state and FSM state.

## Configuration
- Macro: `UART_TX_ARB_LOCK_EN`.
- Defined:
  - Accepting a byte with `req_last[w]`=0 sets the lock with owner w and `lock_active`=1.
  - While locked, only the owner can win.
  - Accepting the owner's byte with `req_last`=1 clears the lock in that same accept cycle, so `lock_active`=0 from the next cycle.
  - Messages from different requesters are never interleaved.
- Undefined: arbitration is per byte, `req_last` is ignored and `lock_active` is tied to 0.

## Test plan
- **Reset/idle:** assert `rst` for 3 cycles with all `req_vld`=0 → every output at its reset value and no `tx_vld` pulse over 50 cycles.
- **Single byte:** `req_vld[2]`=1 with byte 8'hA5, `busy` model rising 1 cycle after `tx_vld` for 20 cycles → `req_rdy`=4'b0100 at t, `tx_vld`=1 and `tx_din`=8'hA5 at t+1, `grant_id`=2, next accept no earlier than the cycle after `busy` falls.
- **Round-robin:** all four requesters held valid with bytes 8'h10..8'h13 → accept order 0,1,2,3,0,1 and exactly one `req_rdy` bit set per accept.
- **Lock (macro defined):** requester 1 sends 3 bytes with `req_last` on the third while requester 0 is constantly valid → grants 1,1,1,0 and `lock_active`=1 for the first two accepts. With the macro undefined → grants 1,0,1,0 (pointer wraps from 1 to 0 via 2,3 idle).
- **Timeout:** `busy` held at 0 after the issue → `busy_timeout` pulses exactly BUSY_TO cycles after WAIT_BUSY entry, then the FSM returns to IDLE and accepts the next request.
- **Reset mid-operation:** assert `rst` during WAIT_DONE while `busy`=1 → FSM in IDLE and outputs at reset values the next cycle. No `tx_vld` appears until `busy`=0 and a new request arrives.
